id_redirect_ctrl: RTL
=====================

// Module: id_redirect_ctrl
// PURPOSE
//  Decode-stage partner of the fetch unit: latches fetched instr/PC into the IF/ID register, resolves
//  beq/j/jal/jr, and drives the fetch unit's redirect/freeze inputs (npc_op, branch_off, jump_idx,
//  jr_target, freeze_pc). Holds a 2-entry in-flight scoreboard (EX, MEM) to detect Tuse/Tnew hazards
//  and inserts bubbles into EX. Branch delay slot architecture: no flush of the instr fetched after a branch.
// PARAMETERS
//  RESET_PC   32'h0000_3000   id_pc value held after reset
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  if_instr    in   32  instr from fetch unit (current fetch PC)
//  if_pc       in   32  PC from fetch unit
//  id_rs_val   in   32  forwarded GPR[rs] for the ID instr (external forwarding mux)
//  id_rt_val   in   32  forwarded GPR[rt] for the ID instr
//  rs_addr     out  5   id_instr[25:21], selects forwarding source
//  rt_addr     out  5   id_instr[20:16]
//  id_instr    out  32  IF/ID register instr
//  id_pc       out  32  IF/ID register PC
//  id_valid    out  1   IF/ID holds a real fetched instr
//  npc_op      out  3   0 PC+4, 1 branch, 2 jump (j/jal), 3 jr
//  branch_off  out  32  sign-extended imm16 (fetch adds off<<2 to delay-slot PC)
//  jump_idx    out  26  id_instr[25:0]
//  jr_target   out  32  id_rs_val
//  freeze_pc   out  1   stall: fetch PC and IF/ID hold
//  ex_bubble   out  1   ID->EX carries a nop this cycle (== freeze_pc)
// BEHAVIOUR
//  - Reset: id_instr 0, id_pc RESET_PC, id_valid 0, both scoreboard slots {reg 0, tnew 0}.
//    All combinational outputs then follow from a nop in ID: npc_op 0, freeze_pc 0.
//  - Decode (id_instr): R-type op 0: addu f 6'h21, subu f 6'h23, jr f 6'h08; ori 6'h0d, lui 6'h0f,
//    lw 6'h23, sw 6'h2b, beq 6'h04, j 6'h02, jal 6'h03. Anything else = nop (no dest, no use).
//  - Dest/Tnew at EX entry: addu/subu rd,1; ori/lui rt,1; lw rt,2; jal 31,0; others none. Dest 0 = none.
//  - Tuse: beq rs0 rt0; jr rs0; addu/subu rs1 rt1; ori/lw rs1; sw rs1 rt2; lui/j/jal none.
//  - Stall = any used src s (s!=0) where the nearest matching slot (EX before MEM) has tnew > Tuse(s).
//    Hence lw->use in ID next cycle: 1 or 2 stalls; ALU->beq/jr: 1 stall; lw in MEM->beq: 1 stall.
//  - freeze_pc = ex_bubble = stall. While stalled npc_op forced 0, IF/ID holds, id_valid holds.
//  - Not stalled: IF/ID <= {if_instr, if_pc}, id_valid <= 1.
//  - npc_op (not stalled): beq & rs_val==rt_val -> 1; beq not equal -> 0; j/jal -> 2; jr -> 3; else 0.
//  - Scoreboard each cycle: MEM <= {EX.reg, sat_dec(EX.tnew)}; EX <= stall ? {0,0} : decode(id).
//    sat_dec(0)=0. WB stage not tracked (tnew 0 there by construction).
//  - Reset has priority over stall: reset mid-stall clears IF/ID and scoreboard, freeze_pc low next cycle.
//  - branch_off/jump_idx/jr_target always driven from id_instr/id_rs_val; only npc_op qualifies them.
// TESTING
//  1 reset 2 cycles -> id_pc 0x3000, id_valid 0, npc_op 0, freeze_pc 0; release -> id_pc follows if_pc.
//  2 lw $8,0($0); beq $8,$9,+3 back-to-back -> freeze_pc 1 for 2 cycles, ex_bubble 1 both, then
//    npc_op 1 iff rs/rt vals equal, branch_off 32'h3.
//  3 addu $31,$1,$2; jr $31 -> 1 stall cycle, then npc_op 3, jr_target = id_rs_val.
//  4 jal 0x0C00400 -> npc_op 2, jump_idx 26'h0C00400, no stall; next jr $31 -> no stall (tnew 0).
//  5 lw $0,0($1); beq $0,$0,-1 -> no stall ($0 never hazards), npc_op 1, branch_off 32'hFFFF_FFFF.
//  6 assert reset during a lw->beq stall -> next cycle freeze_pc 0, scoreboard empty, id_valid 0.

Source files
------------

// File: rtl/id_redirect_ctrl.sv
// Decode stage: IF/ID register, beq/j/jal/jr resolution, and Tuse/Tnew hazard stall against EX/MEM.
// Latency: IF/ID and scoreboard update on the rising edge; redirect and stall outputs are combinational from ID.
// Backpressure: a stall freezes fetch and IF/ID, forces npc_op to PC+4 and injects a bubble into EX.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   if_instr, if_pc        instruction and PC from the fetch unit
//   id_rs_val, id_rt_val   forwarded source operands for the instruction in ID
//   rs_addr, rt_addr       source register fields of the ID instruction (forwarding select)
//   id_instr, id_pc        IF/ID register contents
//   id_valid               IF/ID holds a real fetched instruction
//   npc_op                 0 PC+4, 1 branch taken, 2 j/jal, 3 jr
//   branch_off             sign-extended imm16
//   jump_idx               26-bit jump index
//   jr_target              jr destination (forwarded rs)
//   freeze_pc              hold fetch PC and IF/ID
//   ex_bubble              ID->EX carries a nop this cycle
module id_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [2:0]  npc_op,
  output logic [31:0] branch_off,
  output logic [25:0] jump_idx,
  output logic [31:0] jr_target,
  output logic        freeze_pc,
  output logic        ex_bubble
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] NPC_SEQ    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  // IF/ID register
  logic [31:0] id_instr_q, id_pc_q;
  logic        id_valid_q;

  // In-flight scoreboard: destination register and remaining cycles until its value exists
  logic [4:0] ex_reg_q,  mem_reg_q;
  logic [1:0] ex_tnew_q, mem_tnew_q;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;

  logic [4:0] dst_reg;
  logic [1:0] dst_tnew;
  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic       stall;

  assign op = id_instr_q[31:26];
  assign fn = id_instr_q[5:0];
  assign rs = id_instr_q[25:21];
  assign rt = id_instr_q[20:16];
  assign rd = id_instr_q[15:11];

  // Destination/Tnew produced at EX entry and Tuse per source, for the ID instruction
  always_comb begin
    dst_reg  = 5'd0;
    dst_tnew = 2'd0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    tuse_rs  = 2'd0;
    tuse_rt  = 2'd0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          dst_reg  = rd;
          dst_tnew = 2'd1;
          use_rs   = 1'b1;
          use_rt   = 1'b1;
          tuse_rs  = 2'd1;
          tuse_rt  = 2'd1;
        end else if (fn == FN_JR) begin
          use_rs  = 1'b1;
          tuse_rs = 2'd0;
        end
      end
      OP_ORI: begin
        dst_reg  = rt;
        dst_tnew = 2'd1;
        use_rs   = 1'b1;
        tuse_rs  = 2'd1;
      end
      OP_LUI: begin
        dst_reg  = rt;
        dst_tnew = 2'd1;
      end
      OP_LW: begin
        dst_reg  = rt;
        dst_tnew = 2'd2;
        use_rs   = 1'b1;
        tuse_rs  = 2'd1;
      end
      OP_SW: begin
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
        use_rt  = 1'b1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL: begin
        // Link value is ready at EX entry, so a following jr never waits on it
        dst_reg  = 5'd31;
        dst_tnew = 2'd0;
      end
      default: ;
    endcase
  end

  // Only the nearest producer matters: an EX match shadows an older MEM match of the same register
  function automatic logic src_stall(input logic       used,
                                     input logic [4:0] src,
                                     input logic [1:0] tuse,
                                     input logic [4:0] ex_r,
                                     input logic [1:0] ex_t,
                                     input logic [4:0] mem_r,
                                     input logic [1:0] mem_t);
    logic h;
    h = 1'b0;
    if (used && src != 5'd0) begin
      if (src == ex_r)
        h = (ex_t > tuse);
      else if (src == mem_r)
        h = (mem_t > tuse);
    end
    return h;
  endfunction

  assign stall = src_stall(use_rs, rs, tuse_rs, ex_reg_q, ex_tnew_q, mem_reg_q, mem_tnew_q)
               | src_stall(use_rt, rt, tuse_rt, ex_reg_q, ex_tnew_q, mem_reg_q, mem_tnew_q);

  always_comb begin
    npc_op = NPC_SEQ;
    if (!stall) begin
      case (op)
        OP_BEQ:        npc_op = (id_rs_val == id_rt_val) ? NPC_BRANCH : NPC_SEQ;
        OP_J, OP_JAL:  npc_op = NPC_JUMP;
        OP_RTYPE:      npc_op = (fn == FN_JR) ? NPC_JR : NPC_SEQ;
        default:       npc_op = NPC_SEQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr_q <= 32'd0;
      id_pc_q    <= RESET_PC;
      id_valid_q <= 1'b0;
      ex_reg_q   <= 5'd0;
      ex_tnew_q  <= 2'd0;
      mem_reg_q  <= 5'd0;
      mem_tnew_q <= 2'd0;
    end else begin
      if (!stall) begin
        id_instr_q <= if_instr;
        id_pc_q    <= if_pc;
        id_valid_q <= 1'b1;
      end
      mem_reg_q  <= ex_reg_q;
      mem_tnew_q <= (ex_tnew_q == 2'd0) ? 2'd0 : ex_tnew_q - 2'd1;
      ex_reg_q   <= stall ? 5'd0 : dst_reg;
      ex_tnew_q  <= stall ? 2'd0 : dst_tnew;
    end
  end

  assign rs_addr    = rs;
  assign rt_addr    = rt;
  assign id_instr   = id_instr_q;
  assign id_pc      = id_pc_q;
  assign id_valid   = id_valid_q;
  assign branch_off = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
  assign jump_idx   = id_instr_q[25:0];
  assign jr_target  = id_rs_val;
  assign freeze_pc  = stall;
  assign ex_bubble  = stall;

endmodule
